// File: rtl/qea_host_sequencer.sv
`timescale 1ns/1ps
// Host-side load / start / readback sequencer for one QEA core instance.
// Define QEA_SEQ_CYCLE_COUNT_EN to get a saturating execution-cycle counter on o_exec_cycles.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_DATA_WIDTH        = DATA_WIDTH*2,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic                                 i_abort,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [31:0]                          o_exec_cycles
);

    localparam int WORD_W = PE_NUM*STATE_DATA_WIDTH;
    localparam logic [MAX_QBIT_WIDTH-1:0] PNW_Q = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] SAW_Q = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONE_FX = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << NUM_FRAC_BIT;
    // |0...0>: real part 1.0 in the most significant amplitude slot, everything else zero
    localparam logic [WORD_W-1:0] INIT_WORD0 = {ONE_FX, {(WORD_W-DATA_WIDTH){1'b0}}};
    localparam logic [STATE_ADDR_WIDTH-1:0] SADDR_ONE = {{(STATE_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] CADDR_ONE = {{(GATE_CONTEXT_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD_CTX = 4'd1,
        S_INIT_ST  = 4'd2,
        S_START    = 4'd3,
        S_WAIT     = 4'd4,
        S_RD_ISSUE = 4'd5,
        S_RD_CAP   = 4'd6,
        S_RD_OUT   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // Last state-word address (nwords-1); clamps to all-ones when nwords exceeds the address space.
    function automatic logic [STATE_ADDR_WIDTH-1:0] last_addr_f(input logic [MAX_QBIT_WIDTH-1:0] qbit);
        logic [MAX_QBIT_WIDTH-1:0] sh;
        logic [STATE_ADDR_WIDTH:0] pow;
        sh  = qbit - PNW_Q;
        pow = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1} << sh;
        if (qbit <= PNW_Q) begin
            return {STATE_ADDR_WIDTH{1'b0}};
        end else if (sh >= SAW_Q) begin
            return {STATE_ADDR_WIDTH{1'b1}};
        end else begin
            return pow[STATE_ADDR_WIDTH-1:0] - SADDR_ONE;
        end
    endfunction

    state_t                               state_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_num_q;
    logic [STATE_ADDR_WIDTH-1:0]          last_addr_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   beat_q;
    logic [STATE_ADDR_WIDTH-1:0]          raddr_q;
    logic                                 wait_first_q;
    logic                                 ctx_ready_q, ctx_en_q, ctx_wea_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q;
    logic                                 st_ena_q, st_wea_q;
    logic [STATE_ADDR_WIDTH-1:0]          st_addra_q;
    logic [WORD_W-1:0]                    st_dina_q;
    logic                                 start_q, rd_valid_q, busy_q, done_q;
    logic [WORD_W-1:0]                    rd_data_q;
    logic [STATE_ADDR_WIDTH-1:0]          rd_addr_q;

    logic                                 ctx_hs_s;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   beat_d;
    logic [STATE_ADDR_WIDTH-1:0]          init_addr_d;
    logic [STATE_ADDR_WIDTH-1:0]          raddr_d;
    logic [STATE_ADDR_WIDTH-1:0]          run_last_s;

    assign ctx_hs_s    = i_ctx_valid & ctx_ready_q;
    assign beat_d      = beat_q + CADDR_ONE;
    assign init_addr_d = st_addra_q + SADDR_ONE;
    assign raddr_d     = raddr_q + SADDR_ONE;
    assign run_last_s  = last_addr_f(i_qbit_num);

    // Sequencer FSM with all handshake / RAM-port outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ins_num_q    <= '0;
            last_addr_q  <= '0;
            beat_q       <= '0;
            raddr_q      <= '0;
            wait_first_q <= 1'b0;
            ctx_ready_q  <= 1'b0;
            ctx_en_q     <= 1'b0;
            ctx_wea_q    <= 1'b0;
            ctx_addr_q   <= '0;
            ctx_data_q   <= '0;
            st_ena_q     <= 1'b0;
            st_wea_q     <= 1'b0;
            st_addra_q   <= '0;
            st_dina_q    <= '0;
            start_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ctx_en_q  <= 1'b0;
            ctx_wea_q <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            if (i_abort) begin
                state_q      <= S_IDLE;
                ins_num_q    <= '0;
                last_addr_q  <= '0;
                beat_q       <= '0;
                raddr_q      <= '0;
                wait_first_q <= 1'b0;
                ctx_ready_q  <= 1'b0;
                st_ena_q     <= 1'b0;
                st_wea_q     <= 1'b0;
                rd_valid_q   <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_run) begin
                            ins_num_q   <= i_ins_num;
                            last_addr_q <= run_last_s;
                            beat_q      <= '0;
                            raddr_q     <= '0;
                            busy_q      <= 1'b1;
                            if (i_ins_num == '0) begin
                                state_q    <= S_INIT_ST;
                                st_ena_q   <= 1'b1;
                                st_wea_q   <= 1'b1;
                                st_addra_q <= '0;
                                st_dina_q  <= INIT_WORD0;
                            end else begin
                                state_q     <= S_LOAD_CTX;
                                ctx_ready_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_CTX: begin
                        if (ctx_hs_s) begin
                            ctx_en_q   <= 1'b1;
                            ctx_wea_q  <= 1'b1;
                            ctx_addr_q <= beat_q;
                            ctx_data_q <= i_ctx_data;
                            beat_q     <= beat_d;
                            if (beat_d == ins_num_q) begin
                                ctx_ready_q <= 1'b0;
                            end
                        end else if (!ctx_ready_q) begin
                            // final context write was driven last cycle
                            state_q    <= S_INIT_ST;
                            st_ena_q   <= 1'b1;
                            st_wea_q   <= 1'b1;
                            st_addra_q <= '0;
                            st_dina_q  <= INIT_WORD0;
                        end
                    end
                    S_INIT_ST: begin
                        st_dina_q <= '0;
                        if (st_addra_q == last_addr_q) begin
                            st_ena_q   <= 1'b0;
                            st_wea_q   <= 1'b0;
                            st_addra_q <= '0;
                            start_q    <= 1'b1;
                            state_q    <= S_START;
                        end else begin
                            st_addra_q <= init_addr_d;
                        end
                    end
                    S_START: begin
                        wait_first_q <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                    S_WAIT: begin
                        // the core clears complete during the first wait cycle, so it is ignored there
                        wait_first_q <= 1'b0;
                        if (!wait_first_q && i_complete) begin
                            raddr_q    <= '0;
                            st_ena_q   <= 1'b1;
                            st_wea_q   <= 1'b0;
                            st_addra_q <= '0;
                            state_q    <= S_RD_ISSUE;
                        end
                    end
                    S_RD_ISSUE: begin
                        st_ena_q <= 1'b0;
                        state_q  <= S_RD_CAP;
                    end
                    S_RD_CAP: begin
                        rd_data_q  <= i_state_dout;
                        rd_addr_q  <= raddr_q;
                        rd_valid_q <= 1'b1;
                        state_q    <= S_RD_OUT;
                    end
                    S_RD_OUT: begin
                        if (i_rd_ready) begin
                            rd_valid_q <= 1'b0;
                            if (raddr_q == last_addr_q) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                raddr_q    <= raddr_d;
                                st_ena_q   <= 1'b1;
                                st_wea_q   <= 1'b0;
                                st_addra_q <= raddr_d;
                                state_q    <= S_RD_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        ctx_ready_q <= 1'b0;
                        st_ena_q    <= 1'b0;
                        st_wea_q    <= 1'b0;
                        rd_valid_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef QEA_SEQ_CYCLE_COUNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] exec_q;

    // Counts cycles from the start pulse; holds its value outside WAIT and across aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q <= 32'd0;
        end else if (!i_abort) begin
            if (state_q == S_START) begin
                exec_q <= 32'd0;
            end else if (state_q == S_WAIT) begin
                exec_q <= sat_inc32(exec_q);
            end
        end
    end

    assign o_exec_cycles = exec_q;
`else
    assign o_exec_cycles = 32'd0;
`endif

    assign o_ctx_ready   = ctx_ready_q;
    assign o_ctx_en      = ctx_en_q;
    assign o_ctx_wea     = ctx_wea_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = st_ena_q;
    assign o_state_wea   = st_wea_q;
    assign o_state_addra = st_addra_q;
    assign o_state_dina  = st_dina_q;
    assign o_start       = start_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
Autonomous host-side controller for the QEA core. It streams gate-context words into the QEA context RAM and initialises the state RAM to |0...0>. It then pulses start, waits for completion and streams every state word back out through a ready/valid port. This replaces the hand-written load/start/readback sequencing in the simulation benches and sits between the host interface and one QEA instance.

Parameters:
PE_NUM_WIDTH, 2, log2 of PE count
PE_NUM, 4, PEs; one state word = PE_NUM amplitudes
DATA_WIDTH, 32, real/imag component width
MAX_QBIT_WIDTH, 6, width of qubit-count field
STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude {re,im}
STATE_ADDR_WIDTH, 16, state RAM address width
GATE_CONTEXT_DATA_WIDTH, DATA_WIDTH*2, context word width
GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 1<<NUM_FRAC_BIT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_run  in  1  start a full job; sampled only in IDLE
i_abort  in  1  synchronous abort to IDLE from any state
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on i_run
i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  number of context words, latched on i_run
i_ctx_valid / o_ctx_ready  in/out  1  context-stream handshake
i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
o_ctx_en, o_ctx_wea  out  1  QEA context RAM enable/write
o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context write address
o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context write data
o_state_ena, o_state_wea  out  1  QEA state RAM enable/write (replicated to all PE banks by wrapper)
o_state_addra  out  STATE_ADDR_WIDTH  state address
o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state write data
o_start  out  1  QEA start pulse
i_complete  in  1  QEA completion level
i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA state read data (1-cycle latency)
o_rd_valid / i_rd_ready  out/in  1  readback handshake
o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readback word
o_rd_addr  out  STATE_ADDR_WIDTH  address of o_rd_data
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse after the last readback beat
o_exec_cycles  out  32  clk cycles from o_start to the first sampled i_complete

Behaviour:
- Reset: every output is 0, FSM is IDLE, all counters are 0.
- FSM: IDLE -> LOAD_CTX -> INIT_ST -> START -> WAIT -> RD_ISSUE -> RD_CAP -> RD_OUT -> (RD_ISSUE | DONE) -> IDLE.
- IDLE: on i_run, latch qbit_num and ins_num. Compute nwords = 2**(qbit_num-PE_NUM_WIDTH); if qbit_num<=PE_NUM_WIDTH, nwords = 1. Go to LOAD_CTX, or to INIT_ST if ins_num==0.
- LOAD_CTX: o_ctx_ready=1 while beats<ins_num.
  - Each handshake registers o_ctx_en=o_ctx_wea=1, o_ctx_addr=beat index (0..ins_num-1) and o_ctx_data for exactly the next cycle.
  - Cycles without a handshake have o_ctx_en=0.
  - After the last handshake, o_ctx_ready drops in the same cycle and the FSM enters INIT_ST once the final write has been driven.
- INIT_ST: one write per cycle, addr 0..nwords-1, o_state_ena=o_state_wea=1.
  - Word 0 data: top STATE_DATA_WIDTH slot = {1<<NUM_FRAC_BIT as DATA_WIDTH, 0}; every other slot 0.
  - All other words: 0.
- START: o_start=1 for exactly one cycle. Cycle counter clears to 0.
- WAIT: i_complete is ignored in the first WAIT cycle (QEA clears complete). From the second WAIT cycle on, the first cycle with i_complete=1 freezes the cycle counter and moves the FSM to RD_ISSUE with address 0.
- RD_ISSUE: o_state_ena=1, wea=0, addra=raddr.
- RD_CAP: capture i_state_dout into o_rd_data and set o_rd_addr=raddr.
- RD_OUT: o_rd_valid=1 with o_rd_data/o_rd_addr held stable until i_rd_ready. On handshake: if raddr==nwords-1, go to DONE; else raddr+1 and go to RD_ISSUE.
- DONE: o_done=1 for one cycle, then IDLE.
- i_abort has priority over every transition:
  - next cycle in IDLE, all enables/valid/start at 0;
  - no o_done;
  - latched config discarded;
  - o_exec_cycles keeps its last value.
- i_run while busy is ignored. i_run and i_abort together in IDLE: stay IDLE.
- Counters: state address counters are STATE_ADDR_WIDTH wide. nwords up to 2**STATE_ADDR_WIDTH with no wrap is legal, because the terminal compare uses nwords-1.

Optional Feature:
QEA_SEQ_CYCLE_COUNT_EN. When defined, o_exec_cycles is a 32-bit counter that saturates at 0xFFFFFFFF, incrementing every WAIT cycle (START cycle counts as 0). When undefined, o_exec_cycles is tied to 0 and the counter logic is absent. All other behaviour is identical in both cases.

Test Plan:
- qbit=9, ins=339, valid always 1 -> 339 consecutive ctx writes at addr 0..338 with matching data; then 128 state writes, word0 = 0x40000000_00000000 in the top slot and 0 elsewhere; then one o_start.
- i_ctx_valid toggling 1/0 -> o_ctx_en high only in cycles after handshakes, addresses still contiguous; ins=0 -> no ctx writes, INIT_ST begins the cycle after i_run.
- Model i_complete after 50 cycles -> o_exec_cycles==50 with macro, 0 without; complete held high at the start pulse -> not accepted until the second WAIT cycle.
- Readback, qbit=9, i_rd_ready random -> 128 beats, o_rd_addr 0..127 in order, data stable while stalled, o_done pulses once.
- qbit=2 -> nwords=1: single init write of the 1.0 word, single readback beat.
- i_abort mid-LOAD_CTX and mid-RD_OUT -> IDLE next cycle, o_busy=0, no o_done; a following i_run completes a clean job.
